// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller and memory.
// Ports: req/we/addr/wdata toward memory, rdata/ack back (+dm_err with MEM_ACCESS_TIMEOUT_EN).
interface mem_access_ctrl_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
`ifdef MEM_ACCESS_TIMEOUT_EN
  logic        dm_err;
`endif

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
`ifdef MEM_ACCESS_TIMEOUT_EN
    output dm_err,
`endif
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
`ifdef MEM_ACCESS_TIMEOUT_EN
    input  dm_err,
`endif
    output dm_rdata, dm_ack
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM stage: stalls EX/MEM around a data-memory access, resolves branches,
// and drives MEM/WB. Ports: clk, rst (async low), EX/MEM inputs, dm bus
// (master), EX_MEM_WR/pc_src/pc_target, MEM/WB outputs.
// Option: MEM_ACCESS_TIMEOUT_EN adds a 15-cycle ack timeout and sticky dm_err.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] NPC_IN,
  input  logic [31:0] ALU_C_IN,
  input  logic [31:0] RT_DATA_IN,
  input  logic        ZERO_IN,
  input  logic [1:0]  Branch_IN,
  input  logic        MEMR_IN,
  input  logic        MEMW_IN,
  input  logic        REGW_IN,
  input  logic        MEM2R_IN,
  input  logic [4:0]  reg_rd_in,
  mem_access_ctrl_if.master dm,
  output logic        EX_MEM_WR,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic [31:0] MEM_DATA_OUT,
  output logic [31:0] ALU_C_OUT,
  output logic [4:0]  reg_rd_out,
  output logic        REGW_OUT,
  output logic        MEM2R_OUT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nxt;
  logic        r_dm_req;
  logic        r_dm_we;
  logic [31:0] r_dm_addr;
  logic [31:0] r_dm_wdata;
  logic [31:0] r_load;
  logic        w_start;
  logic        w_ack;
  logic        w_to;

  assign w_start = (r_state == IDLE) && (MEMR_IN || MEMW_IN);
  assign w_ack   = (r_state == BUSY) && dm.dm_ack;

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [3:0] r_cnt;
  logic       r_err;

  // 15th consecutive BUSY cycle without ack aborts the access
  assign w_to = (r_state == BUSY) && !dm.dm_ack && (r_cnt == 4'd14);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 4'd0;
      r_err <= 1'b0;
    end else begin
      if (w_start)
        r_cnt <= 4'd0;
      else if (r_state == BUSY && !dm.dm_ack)
        r_cnt <= r_cnt + 4'd1;
      if (w_to)
        r_err <= 1'b1;
    end
  end

  assign dm.dm_err = r_err;
`else
  assign w_to = 1'b0;
`endif

  always_comb begin
    w_nxt     = r_state;
    EX_MEM_WR = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start) w_nxt = BUSY;
        else         EX_MEM_WR = 1'b1;
      end
      BUSY: begin
        if (w_ack || w_to) w_nxt = DONE;
      end
      DONE: begin
        EX_MEM_WR = 1'b1;
        w_nxt     = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nxt;
  end

  // Bus fields latched on BUSY entry so they stay stable while waiting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dm_req   <= 1'b0;
      r_dm_we    <= 1'b0;
      r_dm_addr  <= 32'd0;
      r_dm_wdata <= 32'd0;
    end else begin
      r_dm_req <= (w_nxt == BUSY);
      if (w_start) begin
        r_dm_we    <= MEMW_IN;
        r_dm_addr  <= {ALU_C_IN[31:2], 2'b00};
        r_dm_wdata <= RT_DATA_IN;
      end else if (w_nxt != BUSY) begin
        r_dm_we <= 1'b0;
      end
    end
  end

  assign dm.dm_req   = r_dm_req;
  assign dm.dm_we    = r_dm_we;
  assign dm.dm_addr  = r_dm_addr;
  assign dm.dm_wdata = r_dm_wdata;

  // Load register: zero unless this access was an acked read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_load <= 32'd0;
    else if (w_start || w_to)
      r_load <= 32'd0;
    else if (w_ack && !r_dm_we)
      r_load <= dm.dm_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MEM_DATA_OUT <= 32'd0;
      ALU_C_OUT    <= 32'd0;
      reg_rd_out   <= 5'd0;
      REGW_OUT     <= 1'b0;
      MEM2R_OUT    <= 1'b0;
    end else if (EX_MEM_WR) begin
      MEM_DATA_OUT <= (r_state == DONE) ? r_load : 32'd0;
      ALU_C_OUT    <= ALU_C_IN;
      reg_rd_out   <= reg_rd_in;
      REGW_OUT     <= REGW_IN;
      MEM2R_OUT    <= MEM2R_IN;
    end else begin
      REGW_OUT  <= 1'b0;
      MEM2R_OUT <= 1'b0;
    end
  end

  always_comb begin
    pc_src = 1'b0;
    if (r_state == IDLE) begin
      unique case (1'b1)
        (Branch_IN == 2'b01): pc_src = ZERO_IN;
        (Branch_IN == 2'b10): pc_src = !ZERO_IN;
        default:              pc_src = 1'b0;
      endcase
    end
  end

  assign pc_target = NPC_IN;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: load, store, branch, reset, timeout.
// Checks go through chk(); summary line reports totals.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] NPC_IN, ALU_C_IN, RT_DATA_IN;
  logic        ZERO_IN;
  logic [1:0]  Branch_IN;
  logic        MEMR_IN, MEMW_IN, REGW_IN, MEM2R_IN;
  logic [4:0]  reg_rd_in;
  logic        EX_MEM_WR, pc_src;
  logic [31:0] pc_target, MEM_DATA_OUT, ALU_C_OUT;
  logic [4:0]  reg_rd_out;
  logic        REGW_OUT, MEM2R_OUT;
  int          n_chk = 0;
  int          n_err = 0;

  mem_access_ctrl_if dmi ();

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .NPC_IN(NPC_IN), .ALU_C_IN(ALU_C_IN), .RT_DATA_IN(RT_DATA_IN),
    .ZERO_IN(ZERO_IN), .Branch_IN(Branch_IN),
    .MEMR_IN(MEMR_IN), .MEMW_IN(MEMW_IN),
    .REGW_IN(REGW_IN), .MEM2R_IN(MEM2R_IN), .reg_rd_in(reg_rd_in),
    .dm(dmi.master),
    .EX_MEM_WR(EX_MEM_WR), .pc_src(pc_src), .pc_target(pc_target),
    .MEM_DATA_OUT(MEM_DATA_OUT), .ALU_C_OUT(ALU_C_OUT),
    .reg_rd_out(reg_rd_out), .REGW_OUT(REGW_OUT), .MEM2R_OUT(MEM2R_OUT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    MEMR_IN = 0; MEMW_IN = 0; REGW_IN = 0; MEM2R_IN = 0;
    Branch_IN = 2'b00; ZERO_IN = 0;
  endtask

  initial begin
    rst = 1'b0;
    NPC_IN = 0; ALU_C_IN = 0; RT_DATA_IN = 0; reg_rd_in = 0;
    idle_in();
    dmi.dm_ack = 0; dmi.dm_rdata = 0;
    #2;
    chk("rst_req", 32'(dmi.dm_req), 0);
    chk("rst_we", 32'(dmi.dm_we), 0);
    chk("rst_mdata", MEM_DATA_OUT, 0);
    chk("rst_regw", 32'(REGW_OUT), 0);
    #10 rst = 1'b1;
    step();
    chk("idle_wr", 32'(EX_MEM_WR), 1);

    // load with ack in second BUSY cycle
    MEMR_IN = 1; ALU_C_IN = 32'h13; REGW_IN = 1; MEM2R_IN = 1;
    reg_rd_in = 5'd5; Branch_IN = 2'b10; ZERO_IN = 0;
    #1;
    chk("ld_wr0", 32'(EX_MEM_WR), 0);
    step();
    chk("ld_req1", 32'(dmi.dm_req), 1);
    chk("ld_addr", dmi.dm_addr, 32'h10);
    chk("ld_we", 32'(dmi.dm_we), 0);
    chk("ld_wr1", 32'(EX_MEM_WR), 0);
    chk("ld_bub1", 32'(REGW_OUT), 0);
    chk("busy_pcsrc", 32'(pc_src), 0);
    step();
    chk("ld_req2", 32'(dmi.dm_req), 1);
    chk("ld_addr2", dmi.dm_addr, 32'h10);
    chk("ld_wr2", 32'(EX_MEM_WR), 0);
    dmi.dm_ack = 1; dmi.dm_rdata = 32'hDEADBEEF;
    step();
    dmi.dm_ack = 0; dmi.dm_rdata = 0;
    chk("ld_done_req", 32'(dmi.dm_req), 0);
    chk("ld_done_wr", 32'(EX_MEM_WR), 1);
    chk("ld_bub3", 32'(REGW_OUT), 0);
    step();
    chk("ld_mdata", MEM_DATA_OUT, 32'hDEADBEEF);
    chk("ld_alu", ALU_C_OUT, 32'h13);
    chk("ld_rd", 32'(reg_rd_out), 5);
    chk("ld_regw", 32'(REGW_OUT), 1);
    chk("ld_m2r", 32'(MEM2R_OUT), 1);

    // store (MEMW wins over MEMR), immediate ack
    MEMR_IN = 1; MEMW_IN = 1; REGW_IN = 0; MEM2R_IN = 0;
    ALU_C_IN = 32'h24; RT_DATA_IN = 32'h12345678; reg_rd_in = 5'd9;
    Branch_IN = 2'b00;
    step();
    chk("st_req", 32'(dmi.dm_req), 1);
    chk("st_we", 32'(dmi.dm_we), 1);
    chk("st_wdata", dmi.dm_wdata, 32'h12345678);
    chk("st_bub", 32'(REGW_OUT), 0);
    chk("st_bubm", 32'(MEM2R_OUT), 0);
    dmi.dm_ack = 1;
    step();
    dmi.dm_ack = 0;
    chk("st_req_off", 32'(dmi.dm_req), 0);
    chk("st_we_off", 32'(dmi.dm_we), 0);
    chk("st_done_wr", 32'(EX_MEM_WR), 1);
    step();
    chk("st_mdata", MEM_DATA_OUT, 0);
    chk("st_alu", ALU_C_OUT, 32'h24);
    chk("st_rd", 32'(reg_rd_out), 9);

    // ALU op, ack ignored in IDLE
    idle_in();
    ALU_C_IN = 32'hCAFE0001; reg_rd_in = 5'd7; REGW_IN = 1;
    dmi.dm_ack = 1;
    #1;
    chk("alu_wr", 32'(EX_MEM_WR), 1);
    step();
    dmi.dm_ack = 0;
    chk("alu_req", 32'(dmi.dm_req), 0);
    chk("alu_out", ALU_C_OUT, 32'hCAFE0001);
    chk("alu_regw", 32'(REGW_OUT), 1);
    chk("alu_mdata", MEM_DATA_OUT, 0);
    chk("alu_wr2", 32'(EX_MEM_WR), 1);

    // branch decode
    NPC_IN = 32'h00400040; Branch_IN = 2'b10; ZERO_IN = 0;
    #1;
    chk("br10_z0", 32'(pc_src), 1);
    chk("br_tgt", pc_target, 32'h00400040);
    Branch_IN = 2'b11; #1;
    chk("br11_z0", 32'(pc_src), 0);
    Branch_IN = 2'b10; ZERO_IN = 1; #1;
    chk("br10_z1", 32'(pc_src), 0);
    Branch_IN = 2'b01; #1;
    chk("br01_z1", 32'(pc_src), 1);
    ZERO_IN = 0; #1;
    chk("br01_z0", 32'(pc_src), 0);
    Branch_IN = 2'b00; ZERO_IN = 1; #1;
    chk("br00_z1", 32'(pc_src), 0);
    step();

    // reset in second BUSY cycle
    idle_in();
    MEMR_IN = 1; ALU_C_IN = 32'h40; REGW_IN = 1;
    step();
    step();
    chk("rm_req_pre", 32'(dmi.dm_req), 1);
    #2 rst = 1'b0;
    #1;
    chk("rm_req", 32'(dmi.dm_req), 0);
    chk("rm_alu", ALU_C_OUT, 0);
    chk("rm_rd", 32'(reg_rd_out), 0);
    chk("rm_regw", 32'(REGW_OUT), 0);
    chk("rm_mdata", MEM_DATA_OUT, 0);
    idle_in();
    #2 rst = 1'b1;
    #1;
    chk("rm_idle_wr", 32'(EX_MEM_WR), 1);
    step();
    chk("rm_req_post", 32'(dmi.dm_req), 0);
    chk("rm_wr_post", 32'(EX_MEM_WR), 1);

`ifdef MEM_ACCESS_TIMEOUT_EN
    begin
      int busy_n = 0;
      MEMR_IN = 1; ALU_C_IN = 32'h80;
      step();
      while (dmi.dm_req && busy_n < 40) begin
        busy_n++;
        step();
      end
      chk("to_busy_n", 32'(busy_n), 15);
      chk("to_done_wr", 32'(EX_MEM_WR), 1);
      chk("to_err", 32'(dmi.dm_err), 1);
      step();
      idle_in();
      chk("to_mdata", MEM_DATA_OUT, 0);
      step();
      step();
      chk("to_err_hold", 32'(dmi.dm_err), 1);
      #2 rst = 1'b0;
      #1;
      chk("to_err_rst", 32'(dmi.dm_err), 0);
      #2 rst = 1'b1;
      step();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
